// File: rtl/fifo_req_sched.sv
// rtl/fifo_req_sched.sv - request scheduler between a producer/consumer pair and a FIFO pointer controller
// Optional flag-consistency checker enabled by macro FIFO_REQ_SCHED_CHK_EN.
module fifo_req_sched #(
   parameter int addresswidth = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_req,
   input  logic                  pop_req,
   input  logic                  emp,
   input  logic                  full,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic                  wr,
   output logic                  rd,
   output logic                  push_ack,
   output logic                  pop_ack,
   output logic [addresswidth:0] occ,
   output logic [7:0]            deny_cnt,
   output logic                  err
);

   localparam logic [addresswidth:0] OCC_MAX = {1'b1, {addresswidth{1'b0}}};
   localparam logic [addresswidth:0] OCC_ONE = {{addresswidth{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic                 r_wr;
   logic                 r_rd;
   logic                 r_push_ack;
   logic                 r_pop_ack;
   logic [addresswidth:0] r_occ;
   logic [7:0]           r_deny_cnt;
   logic                 r_op_rd;      // direction of the transfer in flight (1 = read)
   logic                 r_last_rd;    // direction of the last accepted transfer (1 = read)

   logic                 w_push_elig;
   logic                 w_pop_elig;
   logic                 w_issue_wr;
   logic                 w_issue_rd;
   logic                 w_flag;
   logic                 w_accept;
   logic                 w_refuse;
   logic                 w_wr_nxt;
   logic                 w_rd_nxt;
   logic                 w_push_ack_nxt;
   logic                 w_pop_ack_nxt;

   assign w_push_elig = push_req & ~full;
   assign w_pop_elig  = pop_req & ~emp;

   // When both directions are eligible, serve the one not served last;
   // r_last_rd resets to 1 so that write wins the first contest.
   assign w_issue_wr  = w_push_elig & (~w_pop_elig | r_last_rd);
   assign w_issue_rd  = w_pop_elig & (~w_push_elig | ~r_last_rd);

   // The controller answers through the flag matching the in-flight direction.
   assign w_flag      = r_op_rd ? rd_en : wr_en;
   assign w_accept    = (r_state == S_RESP) & w_flag;
   assign w_refuse    = (r_state == S_RESP) & ~w_flag;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: IDLE waits for an eligible request, ISSUE and RESP each last one cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_issue_wr | w_issue_rd) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode: next values of the registered request and ack strobes.
   always_comb begin
      w_wr_nxt       = 1'b0;
      w_rd_nxt       = 1'b0;
      w_push_ack_nxt = 1'b0;
      w_pop_ack_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_wr_nxt = w_issue_wr;
            w_rd_nxt = w_issue_rd;
         end
         S_RESP: begin
            w_push_ack_nxt = w_accept & ~r_op_rd;
            w_pop_ack_nxt  = w_accept & r_op_rd;
         end
         default: begin
            w_wr_nxt = 1'b0;
         end
      endcase
   end

   // Registered request/ack strobes, so each is high for exactly one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr       <= 1'b0;
         r_rd       <= 1'b0;
         r_push_ack <= 1'b0;
         r_pop_ack  <= 1'b0;
      end else begin
         r_wr       <= w_wr_nxt;
         r_rd       <= w_rd_nxt;
         r_push_ack <= w_push_ack_nxt;
         r_pop_ack  <= w_pop_ack_nxt;
      end
   end

   // Track the in-flight direction and the last accepted direction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_rd   <= 1'b0;
         r_last_rd <= 1'b1;
      end else begin
         if ((r_state == S_IDLE) && (w_issue_wr || w_issue_rd)) begin
            r_op_rd <= w_issue_rd;
         end
         if (w_accept) begin
            r_last_rd <= r_op_rd;
         end
      end
   end

   // Shadow occupancy, clamped at both ends instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ <= '0;
      end else if (w_accept) begin
         if (!r_op_rd && (r_occ != OCC_MAX)) begin
            r_occ <= r_occ + OCC_ONE;
         end else if (r_op_rd && (r_occ != '0)) begin
            r_occ <= r_occ - OCC_ONE;
         end
      end
   end

   // Saturating count of refused transfers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_deny_cnt <= 8'd0;
      end else if (w_refuse && (r_deny_cnt != 8'hFF)) begin
         r_deny_cnt <= r_deny_cnt + 8'd1;
      end
   end

`ifdef FIFO_REQ_SCHED_CHK_EN
   logic r_err;
   logic w_chk_bad;

   // Controller flags must agree with the shadow count whenever we are idle.
   assign w_chk_bad = (r_state == S_IDLE) &&
                      ((emp && (r_occ != '0)) || (full && (r_occ != OCC_MAX)) || (emp && full));

   // Sticky error, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_chk_bad) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign wr       = r_wr;
   assign rd       = r_rd;
   assign push_ack = r_push_ack;
   assign pop_ack  = r_pop_ack;
   assign occ      = r_occ;
   assign deny_cnt = r_deny_cnt;

endmodule

// File: tb/tb_fifo_req_sched.sv
// tb/tb_fifo_req_sched.sv - randomized self-checking bench for fifo_req_sched
module tb_fifo_req_sched;

   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push_req = 1'b0;
   logic          pop_req = 1'b0;
   logic          emp = 1'b1;
   logic          full = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          wr;
   logic          rd;
   logic          push_ack;
   logic          pop_ack;
   logic [AW:0]   occ;
   logic [7:0]    deny_cnt;
   logic          err;

   always #5 clk = ~clk;

   fifo_req_sched #(.addresswidth(AW)) dut (
      .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req),
      .emp(emp), .full(full), .wr_en(wr_en), .rd_en(rd_en),
      .wr(wr), .rd(rd), .push_ack(push_ack), .pop_ack(pop_ack),
      .occ(occ), .deny_cnt(deny_cnt), .err(err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
   endtask

   // Reference: a transfer issued at edge n shows its request during the
   // following cycle and is resolved at edge n+2 from the flag then present.
   int  m_age = -1;      // edges since issue, -1 when no transfer outstanding
   bit  m_op_rd = 0;
   bit  m_last_rd = 1;
   int  m_occ = 0;
   int  m_deny = 0;
   bit  m_err = 0;
   bit  m_wr = 0, m_rd = 0, m_pack = 0, m_qack = 0;

   // Controller stand-in: a real FIFO count that may refuse on demand.
   int  ctl_count = 0;
   int  refuse_pct = 0;
   bit  force_emp = 0;
   int  p_push = 0, p_pop = 0;

   function automatic void model_reset();
      m_age = -1; m_op_rd = 0; m_last_rd = 1; m_occ = 0; m_deny = 0; m_err = 0;
      m_wr = 0; m_rd = 0; m_pack = 0; m_qack = 0;
   endfunction

   function automatic void model_step();
      bit pe, qe, ok;
      pe = push_req && !full;
      qe = pop_req && !emp;
      if (rst) begin
         model_reset();
         return;
      end
`ifdef FIFO_REQ_SCHED_CHK_EN
      if (m_age < 0 && ((emp && m_occ != 0) || (full && m_occ != DEPTH) || (emp && full))) m_err = 1;
`endif
      m_wr = 0; m_rd = 0; m_pack = 0; m_qack = 0;
      if (m_age < 0) begin
         if (pe || qe) begin
            m_op_rd = (pe && qe) ? !m_last_rd : qe;
            m_wr = !m_op_rd;
            m_rd = m_op_rd;
            m_age = 0;
         end
      end else if (m_age == 0) begin
         m_age = 1;
      end else begin
         ok = m_op_rd ? rd_en : wr_en;
         if (ok) begin
            if (m_op_rd) begin m_qack = 1; m_occ = (m_occ > 0) ? m_occ - 1 : 0; end
            else begin m_pack = 1; m_occ = (m_occ < DEPTH) ? m_occ + 1 : DEPTH; end
            m_last_rd = m_op_rd;
         end else begin
            m_deny = (m_deny < 255) ? m_deny + 1 : 255;
         end
         m_age = -1;
      end
   endfunction

   task automatic check_outputs();
      check("wr", wr, m_wr);
      check("rd", rd, m_rd);
      check("push_ack", push_ack, m_pack);
      check("pop_ack", pop_ack, m_qack);
      check("occ", occ, m_occ);
      check("deny_cnt", deny_cnt, m_deny);
      check("err", err, m_err);
      check("wr_rd_excl", wr & rd, 0);
   endtask

   task automatic apply_ctl_flags();
      emp  = force_emp || (ctl_count == 0);
      full = (ctl_count == DEPTH);
   endtask

   task automatic cycle();
      bit nwe, nre;
      @(posedge clk);
      #1;
      nwe = 0; nre = 0;
      if (rst) begin
         ctl_count = 0;
      end else begin
         if (m_wr && ctl_count < DEPTH && $urandom_range(99) >= refuse_pct) begin
            nwe = 1; ctl_count++;
         end
         if (m_rd && ctl_count > 0 && $urandom_range(99) >= refuse_pct) begin
            nre = 1; ctl_count--;
         end
      end
      model_step();
      check_outputs();
      wr_en = nwe;
      rd_en = nre;
      apply_ctl_flags();
      push_req = ($urandom_range(99) < p_push);
      pop_req  = ($urandom_range(99) < p_pop);
   endtask

   task automatic async_reset();
      rst = 1;
      #1;
      model_reset();
      check("rst_async_wr", wr, 0);
      check("rst_async_rd", rd, 0);
      check("rst_async_pack", push_ack, 0);
      check("rst_async_qack", pop_ack, 0);
      check("rst_async_occ", occ, 0);
      check("rst_async_deny", deny_cnt, 0);
      check("rst_async_err", err, 0);
      ctl_count = 0;
      wr_en = 0; rd_en = 0;
      apply_ctl_flags();
      cycle();
      rst = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      bit seen;
      cycle();
      cycle();
      // first request issued on the first edge after release
      p_push = 100; p_pop = 0; refuse_pct = 0;
      push_req = 1; pop_req = 0;
      rst = 0;
      cycle();
      check("s1_wr_cycle1", wr, 1);
      cycle();
      cycle();
      check("s1_ack_cycle3", push_ack, 1);
      check("s1_occ", occ, 1);

      // fill to the top, then requests with full=1 must not issue
      run(120);
      check("fill_occ", occ, DEPTH);
      check("fill_full", full, 1);
      run(12);
      check("full_occ_hold", occ, DEPTH);

      // drain
      p_push = 0; p_pop = 100;
      run(120);
      check("drain_occ", occ, 0);

      // both held: alternate starting with write
      p_push = 100; p_pop = 100;
      run(60);

      // forced refusals saturate deny_cnt
      p_push = 0; p_pop = 100;
      run(10);
      p_push = 100; p_pop = 0; refuse_pct = 100;
      run(920);
      check("deny_sat", deny_cnt, 255);
      refuse_pct = 0;

      // reset during RESP aborts the transfer
      p_push = 100; p_pop = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         seen = wr;
      end
      check("reach_issue", seen, 1);
      cycle();
      p_push = 0;
      async_reset();
      push_req = 0;
      run(5);
      check("post_rst_occ", occ, 0);

`ifdef FIFO_REQ_SCHED_CHK_EN
      p_push = 100; p_pop = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cycle();
         seen = (occ == 3);
      end
      check("chk_occ3", occ, 3);
      p_push = 0;
      run(4);
      force_emp = 1;
      apply_ctl_flags();
      run(3);
      check("chk_err_set", err, 1);
      force_emp = 0;
      run(3);
      check("chk_err_sticky", err, 1);
      async_reset();
      check("chk_err_clear", err, 0);
`endif

      // randomized traffic with refusals and occasional resets
      refuse_pct = 20;
      for (int blk = 0; blk < 60; blk++) begin
         p_push = $urandom_range(100);
         p_pop  = $urandom_range(100);
         for (int i = 0; i < 50; i++) begin
            if ($urandom_range(299) == 0) async_reset();
            else cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
